// File: rtl/audio_pkg.sv
// Shared audio sample definitions for consumers of the I2S receiver.
package audio_pkg;

  localparam int SAMPLE_WIDTH = 16;

  typedef struct packed {
    logic [SAMPLE_WIDTH-1:0] left;
    logic [SAMPLE_WIDTH-1:0] right;
  } stereo_sample_t;

endpackage

// File: rtl/stereo_sample_fifo.sv
// Show-ahead FIFO for stereo PCM pairs between the I2S receiver and a stalling
// consumer. Pairs arriving while full are dropped and counted (saturating).
module stereo_sample_fifo
  import audio_pkg::*;
#(
  parameter int SAMPLE_WIDTH   = audio_pkg::SAMPLE_WIDTH,
  parameter int DEPTH          = 16,
  parameter int DROP_CNT_WIDTH = 8
) (
  input  logic                      clock_in,
  input  logic                      reset_in,
  input  logic [SAMPLE_WIDTH-1:0]   left_sample_in,
  input  logic [SAMPLE_WIDTH-1:0]   right_sample_in,
  input  logic                      new_sample_in,
  output logic [SAMPLE_WIDTH-1:0]   left_sample_out,
  output logic [SAMPLE_WIDTH-1:0]   right_sample_out,
  output logic                      valid_out,
  input  logic                      ready_in,
  output logic [$clog2(DEPTH):0]    count_out,
  output logic                      overflow_out,
  output logic [DROP_CNT_WIDTH-1:0] dropped_count_out,
  input  logic                      overflow_clear_in
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = 2 * SAMPLE_WIDTH;

  logic [DW-1:0]             mem [DEPTH];
  logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]             count_q, count_d;
  logic                      overflow_q, overflow_d;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  logic valid;
  logic full;
  logic push;
  logic pop;
  logic drop;

  // Handshake decode: a pop frees a slot, so a full FIFO still accepts a
  // push in the same cycle.
  always_comb begin
    valid = (count_q != '0);
    full  = (count_q == CW'(DEPTH));
    pop   = valid & ready_in;
    push  = new_sample_in & (~full | pop);
    drop  = new_sample_in & full & ~pop;
  end

  // Next-state for pointers, occupancy and overflow bookkeeping.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;

    // A drop in the same cycle as a clear wins, so the drop is never lost.
    if (drop) begin
      overflow_d = 1'b1;
      if (overflow_clear_in)  drop_cnt_d = DROP_CNT_WIDTH'(1);
      else if (!(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + 1'b1;
    end else if (overflow_clear_in) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  // Control state registers.
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Sample storage; left in the upper half. No reset so it maps to LUT RAM.
  always_ff @(posedge clock_in) begin
    if (push) mem[wr_ptr_q] <= {left_sample_in, right_sample_in};
  end

  // Show-ahead head of queue, forced to zero while empty.
  always_comb begin
    valid_out         = valid;
    left_sample_out   = '0;
    right_sample_out  = '0;
    if (valid) begin
      left_sample_out  = mem[rd_ptr_q][DW-1:SAMPLE_WIDTH];
      right_sample_out = mem[rd_ptr_q][SAMPLE_WIDTH-1:0];
    end
    count_out         = count_q;
    overflow_out      = overflow_q;
    dropped_count_out = drop_cnt_q;
  end

endmodule

// File: tb/tb_stereo_sample_fifo.sv
// Directed plus random stimulus against a queue-based model of the FIFO.
module tb_stereo_sample_fifo;
  import audio_pkg::*;

  localparam int DEPTH   = 16;
  localparam int DCW     = 8;
  localparam int DROPMAX = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] l_in, r_in;
  logic        nw, rdy, clr;
  logic [15:0] l_out, r_out;
  logic        v_out;
  logic [4:0]  cnt_out;
  logic        ovf_out;
  logic [7:0]  drop_out;

  int vectors = 0;
  int miscompares = 0;

  stereo_sample_t mq[$];
  bit             m_ovf;
  int             m_drops;

  always #5 clk = ~clk;

  stereo_sample_fifo #(.SAMPLE_WIDTH(16), .DEPTH(DEPTH), .DROP_CNT_WIDTH(DCW)) dut (
    .clock_in          (clk),
    .reset_in          (rst_n),
    .left_sample_in    (l_in),
    .right_sample_in   (r_in),
    .new_sample_in     (nw),
    .left_sample_out   (l_out),
    .right_sample_out  (r_out),
    .valid_out         (v_out),
    .ready_in          (rdy),
    .count_out         (cnt_out),
    .overflow_out      (ovf_out),
    .dropped_count_out (drop_out),
    .overflow_clear_in (clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [15:0] el, er;
    el = 16'h0;
    er = 16'h0;
    if (mq.size() != 0) begin
      el = mq[0].left;
      er = mq[0].right;
    end
    chk({tag, ".valid"}, {31'd0, v_out}, {31'd0, mq.size() != 0});
    chk({tag, ".count"}, {27'd0, cnt_out}, 32'(mq.size()));
    chk({tag, ".left"},  {16'd0, l_out}, {16'd0, el});
    chk({tag, ".right"}, {16'd0, r_out}, {16'd0, er});
    chk({tag, ".ovf"},   {31'd0, ovf_out}, {31'd0, m_ovf});
    chk({tag, ".drops"}, {24'd0, drop_out}, 32'(m_drops));
  endtask

  // One clock of stimulus; the model advances using the pre-edge state.
  task automatic step(input bit n, input logic [15:0] l, input logic [15:0] r,
                      input bit rd, input bit cl, input string tag);
    bit pop_m, full_m;
    stereo_sample_t s;
    @(negedge clk);
    nw = n; l_in = l; r_in = r; rdy = rd; clr = cl;
    pop_m  = rd && (mq.size() != 0);
    full_m = (mq.size() == DEPTH);
    s.left = l;
    s.right = r;
    if (pop_m) void'(mq.pop_front());
    if (n && (!full_m || pop_m)) mq.push_back(s);
    if (n && full_m && !pop_m) begin
      m_ovf = 1'b1;
      m_drops = cl ? 1 : ((m_drops < DROPMAX) ? m_drops + 1 : DROPMAX);
    end else if (cl) begin
      m_ovf = 1'b0;
      m_drops = 0;
    end
    @(posedge clk);
    #1;
    nw = 1'b0; rdy = 1'b0; clr = 1'b0;
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    nw = 1'b0; rdy = 1'b0; clr = 1'b0; l_in = '0; r_in = '0;
    m_ovf = 1'b0; m_drops = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // single pair through
    step(1, 16'h1234, 16'hABCD, 0, 0, "single_push");
    step(0, 16'h0, 16'h0, 1, 0, "single_pop");
    step(0, 16'h0, 16'h0, 1, 0, "empty_ready");

    // fill, overflow by 3, drain in order
    for (int i = 0; i < DEPTH; i++) step(1, 16'(i), ~16'(i), 0, 0, "fill");
    for (int i = 0; i < 3; i++) step(1, 16'hDEAD, 16'hBEEF, 0, 0, "overflow");
    chk("drops_after_3", {24'd0, drop_out}, 32'd3);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_left", {16'd0, l_out}, 32'(i));
      step(0, 16'h0, 16'h0, 1, 0, "drain");
    end

    // full with simultaneous push and pop
    step(0, 16'h0, 16'h0, 0, 1, "clear_alone");
    for (int i = 0; i < DEPTH; i++) step(1, 16'(i + 32), 16'(i), 0, 0, "fill2");
    step(1, 16'h7777, 16'h8888, 1, 0, "full_push_pop");
    for (int i = 0; i < DEPTH; i++) step(0, 16'h0, 16'h0, 1, 0, "drain2");

    // drop counter saturation, clear coincident with a drop
    for (int i = 0; i < DEPTH; i++) step(1, 16'(i), 16'(i), 0, 0, "fill3");
    for (int i = 0; i < 300; i++) step(1, 16'h1111, 16'h2222, 0, 0, "sat");
    chk("drops_saturated", {24'd0, drop_out}, 32'd255);
    step(1, 16'h3333, 16'h4444, 0, 1, "clear_with_drop");
    step(0, 16'h0, 16'h0, 0, 1, "clear_alone2");
    for (int i = 0; i < DEPTH; i++) step(0, 16'h0, 16'h0, 1, 0, "drain3");

    // random traffic
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 2) != 0), 16'($urandom), 16'($urandom),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0), "random");

    // asynchronous reset mid-stream
    for (int i = 0; i < DEPTH; i++) step(0, 16'h0, 16'h0, 1, 0, "pre_rst_drain");
    for (int i = 0; i < 5; i++) step(1, 16'(i + 100), 16'(i + 200), 0, 0, "load5");
    #2;
    rst_n = 1'b0;
    #1;
    mq.delete();
    m_ovf = 1'b0;
    m_drops = 0;
    check_all("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 16'hA5A5, 16'h5A5A, 0, 0, "post_rst_push");
    step(0, 16'h0, 16'h0, 1, 0, "post_rst_pop");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stereo_sample_fifo.md
Name: stereo_sample_fifo

Overview:
Buffers stereo PCM sample pairs from the I2S microphone receiver (left/right 16-bit words plus a one-cycle new-sample strobe) and presents them to downstream processing (noise-cancellation filter or audio output) through a valid/ready interface. It decouples the free-running ~64 kHz strobe from consumers that stall. Overflow is detected, counted and flagged rather than silently corrupting data. Sits directly downstream of i2s_receiver in top_level.

Parameters:
SAMPLE_WIDTH, 16, bits per channel sample.
DEPTH, 16, number of stereo pairs stored; power of two, minimum 2.
DROP_CNT_WIDTH, 8, width of the saturating dropped-pair counter.

Ports:
clock_in  input  1  system clock, 100 MHz.
reset_in  input  1  asynchronous, active-low reset.
left_sample_in  input  SAMPLE_WIDTH  left channel from receiver.
right_sample_in  input  SAMPLE_WIDTH  right channel from receiver.
new_sample_in  input  1  one-cycle strobe; pair on inputs is valid this cycle.
left_sample_out  output  SAMPLE_WIDTH  head-of-queue left sample.
right_sample_out  output  SAMPLE_WIDTH  head-of-queue right sample.
valid_out  output  1  head-of-queue pair is valid.
ready_in  input  1  consumer accepts head pair when valid_out && ready_in.
count_out  output  $clog2(DEPTH)+1  pairs currently stored.
overflow_out  output  1  sticky: at least one pair dropped since reset/clear.
dropped_count_out  output  DROP_CNT_WIDTH  dropped pairs, saturating at all-ones.
overflow_clear_in  input  1  synchronous clear of overflow_out and dropped_count_out.

Behaviour:
- Reset (reset_in low, async assert, sync-deasserted externally): pointers, count_out, overflow_out, dropped_count_out = 0; valid_out = 0; sample outputs = 0 (array contents need not reset; outputs are masked to 0 while empty).
- Storage: DEPTH x (2*SAMPLE_WIDTH) array; write pointer and read pointer of $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0; count tracked separately (0..DEPTH).
- Push: new_sample_in high and (count < DEPTH or pop this cycle) -> pair written at wr_ptr on rising edge, wr_ptr++.
- Pop: valid_out && ready_in -> rd_ptr++ on rising edge.
- count_out: +1 push only, -1 pop only, unchanged on push+pop or neither.
- Show-ahead: valid_out = (count != 0); outputs = array[rd_ptr] when valid, else 0. Latency push->valid_out = 1 cycle (pair written at edge N visible after edge N).
- Full (count == DEPTH) with push and no pop: incoming pair discarded; stored data untouched; overflow_out set next edge; dropped_count_out++ saturating.
- Full with push and pop same cycle: push accepted, no drop, count stays DEPTH.
- Empty with ready_in high: no pop, no pointer change.
- overflow_clear_in coincident with a drop: the drop wins (overflow_out = 1, dropped_count_out = 1).
- ready_in with valid_out low is ignored; ready_in may toggle freely; outputs stable while valid_out && !ready_in.
- Reset mid-operation: all stored pairs discarded immediately; valid_out drops asynchronously.

Decomposition:
- audio_pkg: SAMPLE_WIDTH constant, stereo_sample_t packed struct {left, right}, shared by i2s_receiver consumers.
- Single module; no sub-module needed. Pointer/count logic and array stay inline (array maps to distributed RAM).

Test Plan:
- Reset then strobe one pair L=16'h1234, R=16'hABCD -> next cycle valid_out=1, outputs 1234/ABCD, count_out=1; ready_in pulse -> valid_out=0, count_out=0.
- ready_in=0, push 16 pairs L=i, R=~i -> count_out=16, no overflow; drain with ready_in=1 -> pairs 0..15 in order, exactly 16 accepts.
- Full FIFO, push 3 more pairs -> overflow_out=1, dropped_count_out=3, drained contents still pairs 0..15.
- Full FIFO, push and ready_in same cycle -> count_out stays 16, overflow_out stays 0, new pair appears last on drain.
- With overflow set, assert overflow_clear_in alone -> overflow_out=0, dropped_count_out=0; force 300 drops -> dropped_count_out saturates at 255.
- Load 5 pairs, pull reset_in low mid-stream -> valid_out=0 and count_out=0 immediately; after release, first push reads back correctly.
